// File: rtl/sprite_pkg.sv
// Shared constants, attribute layout and FSM encoding for the sprite overlay stage.
package sprite_pkg;
    localparam int NSPR     = 8;
    localparam int NSLOT    = 4;
    localparam int V_ACTIVE = 480;

    localparam int X_LSB   = 0;
    localparam int Y_LSB   = 9;
    localparam int PAT_LSB = 17;
    localparam int EN_BIT  = 31;

    localparam logic [2:0] TRANSPARENT = 3'd0;

    typedef enum logic [1:0] {IDLE, EVAL, LOAD} state_t;

    typedef struct packed {
        logic       en;
        logic [3:0] pat;
        logic [7:0] y;
        logic [8:0] x;
    } attr_t;
endpackage

// File: rtl/sprite_pattern_memory.sv
// 4096 x 3 sprite bitmap store: one write port, one registered read port.
module sprite_pattern_memory (
    input  logic        clk,
    input  logic        i_we,
    input  logic [11:0] i_waddr,
    input  logic [2:0]  i_wdata,
    input  logic [11:0] i_raddr,
    output logic [2:0]  o_rdata
);
    logic [2:0] r_mem [4096];
    logic [2:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/sprite_overlay.sv
// Sprite compositing stage: hblank sprite evaluation/row fetch into slots, then
// per-pixel priority overlay on the background colour.
module sprite_overlay
    import sprite_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_wr_en,
    input  logic        i_wr_sel,
    input  logic [11:0] i_wr_addr,
    input  logic [31:0] i_wr_data,
    input  logic [9:0]  i_xpos,
    input  logic [9:0]  i_ypos,
    input  logic        i_active,
    input  logic        i_line_end,
    input  logic [2:0]  i_bg_rgb,
    output logic [2:0]  o_rgb,
    output logic        o_sprite_hit,
    output logic        o_overflow,
    output logic        o_busy
);
    localparam int IW = $clog2(NSPR);
    localparam int SW = $clog2(NSLOT);
    localparam int CW = $clog2(NSLOT + 1);

    state_t           r_state, w_next;
    attr_t            r_attr [NSPR];
    logic [IW-1:0]    r_idx;
    logic [CW-1:0]    r_nslot;
    logic [SW-1:0]    r_ld;
    logic [4:0]       r_col;
    logic             r_ovf_done;
    logic [7:0]       r_ly;
    logic [NSLOT-1:0] r_vld;
    logic [8:0]       r_sx   [NSLOT];
    logic [3:0]       r_spat [NSLOT];
    logic [3:0]       r_srow [NSLOT];
    logic [15:0][2:0] r_spx  [NSLOT];
    logic [2:0]       r_rgb;
    logic             r_hit, r_overflow;

    logic [9:0]  w_ny;
    logic        w_ny_ok, w_isect, w_full, w_last_slot, w_win;
    attr_t       w_cur;
    logic [8:0]  w_dy;
    logic [2:0]  w_rdata, w_pix;
    logic [11:0] w_raddr;
    logic [9:0]  w_dx   [NSLOT];
    logic [2:0]  w_cand [NSLOT];
    logic        w_unused;

    assign w_ny     = i_ypos + 10'd1;
    assign w_ny_ok  = w_ny < 10'(V_ACTIVE);
    assign w_cur    = r_attr[r_idx];
    // 9-bit difference so a sprite above the line (ly < y) never wraps into view.
    assign w_dy     = {1'b0, r_ly} - {1'b0, w_cur.y};
    assign w_isect  = w_cur.en && !w_dy[8] && (w_dy[7:4] == 4'd0);
    assign w_full   = (r_nslot == CW'(NSLOT));
    assign w_last_slot = (CW'(r_ld) == r_nslot - CW'(1));
    assign w_raddr  = {r_spat[r_ld], r_srow[r_ld], r_col[3:0]};
    assign w_unused = ^{i_wr_data[30:21], i_xpos[0]};

    sprite_pattern_memory u_pmem (
        .clk     (clk),
        .i_we    (i_wr_en && i_wr_sel),
        .i_waddr (i_wr_addr),
        .i_wdata (i_wr_data[2:0]),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge clk) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (i_line_end)
            w_next = w_ny_ok ? EVAL : IDLE;
        else begin
            case (r_state)
                EVAL: if (r_idx == IW'(NSPR - 1))
                          w_next = (r_nslot != '0 || w_isect) ? LOAD : IDLE;
                LOAD: if (r_col == 5'd16 && w_last_slot)
                          w_next = IDLE;
                default: w_next = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NSPR; i++) r_attr[i].en <= 1'b0;
            r_vld      <= '0;
            r_idx      <= '0;
            r_nslot    <= '0;
            r_ld       <= '0;
            r_col      <= '0;
            r_ovf_done <= 1'b0;
            r_ly       <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            if (i_wr_en && !i_wr_sel)
                r_attr[i_wr_addr[IW-1:0]] <= '{en:  i_wr_data[EN_BIT],
                                               pat: i_wr_data[PAT_LSB +: 4],
                                               y:   i_wr_data[Y_LSB +: 8],
                                               x:   i_wr_data[X_LSB +: 9]};
            if (i_line_end) begin
                r_vld      <= '0;
                r_idx      <= '0;
                r_nslot    <= '0;
                r_ld       <= '0;
                r_col      <= '0;
                r_ovf_done <= 1'b0;
                r_ly       <= w_ny[8:1];
            end else begin
                case (r_state)
                    EVAL: begin
                        r_idx <= r_idx + IW'(1);
                        if (w_isect && !w_full) begin
                            r_sx[r_nslot[SW-1:0]]   <= w_cur.x;
                            r_spat[r_nslot[SW-1:0]] <= w_cur.pat;
                            r_srow[r_nslot[SW-1:0]] <= w_dy[3:0];
                            r_nslot <= r_nslot + CW'(1);
                        end else if (w_isect && !r_ovf_done) begin
                            r_overflow <= 1'b1;
                            r_ovf_done <= 1'b1;
                        end
                    end
                    LOAD: begin
                        // Read data lags the issued column by one cycle; col 16 is the drain cycle.
                        if (r_col != 5'd0)
                            r_spx[r_ld][4'(r_col - 5'd1)] <= w_rdata;
                        if (r_col == 5'd16) begin
                            r_vld[r_ld] <= 1'b1;
                            r_col       <= '0;
                            r_ld        <= r_ld + SW'(1);
                        end else
                            r_col <= r_col + 5'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar s = 0; s < NSLOT; s++) begin : g_slot
        assign w_dx[s]   = {1'b0, i_xpos[9:1]} - {1'b0, r_sx[s]};
        assign w_cand[s] = (r_vld[s] && w_dx[s][9:4] == 6'd0) ? r_spx[s][w_dx[s][3:0]] : TRANSPARENT;
    end

    always_comb begin
        w_win = 1'b0;
        w_pix = TRANSPARENT;
        for (int s = NSLOT - 1; s >= 0; s--) begin
            if (w_cand[s] != TRANSPARENT) begin
                w_win = 1'b1;
                w_pix = w_cand[s];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_rgb <= '0;
            r_hit <= 1'b0;
        end else begin
            r_rgb <= i_active ? (w_win ? w_pix : i_bg_rgb) : 3'd0;
            r_hit <= i_active && w_win;
        end
    end

    assign o_rgb        = r_rgb;
    assign o_sprite_hit = r_hit;
    assign o_overflow   = r_overflow;
    assign o_busy       = (r_state != IDLE);
endmodule

// File: tb/tb_sprite_overlay.sv
// Directed bench for sprite_overlay: table-driven pixel checks plus fetch/overflow/reset sequences.
module tb_sprite_overlay;
    logic        clk = 1'b0, resetn = 1'b0;
    logic        i_wr_en = 1'b0, i_wr_sel = 1'b0;
    logic [11:0] i_wr_addr = '0;
    logic [31:0] i_wr_data = '0;
    logic [9:0]  i_xpos = '0, i_ypos = '0;
    logic        i_active = 1'b0, i_line_end = 1'b0;
    logic [2:0]  i_bg_rgb = '0;
    logic [2:0]  o_rgb;
    logic        o_sprite_hit, o_overflow, o_busy;

    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    sprite_overlay dut (
        .clk(clk), .resetn(resetn),
        .i_wr_en(i_wr_en), .i_wr_sel(i_wr_sel), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
        .i_xpos(i_xpos), .i_ypos(i_ypos), .i_active(i_active), .i_line_end(i_line_end),
        .i_bg_rgb(i_bg_rgb), .o_rgb(o_rgb), .o_sprite_hit(o_sprite_hit),
        .o_overflow(o_overflow), .o_busy(o_busy)
    );

    typedef struct {
        int         ph;
        logic       act;
        logic [9:0] x;
        logic [2:0] bg;
        logic [2:0] rgb;
        logic       hit;
    } vec_t;
    vec_t tv[$];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input int ph, input logic act, input int x, input int bg, input int rgb, input logic hit);
        vec_t v;
        v.ph = ph; v.act = act; v.x = 10'(x); v.bg = 3'(bg); v.rgb = 3'(rgb); v.hit = hit;
        tv.push_back(v);
    endtask

    task automatic wpix(input int pat, input int row, input int col, input int c);
        i_wr_en = 1'b1; i_wr_sel = 1'b1;
        i_wr_addr = {4'(pat), 4'(row), 4'(col)};
        i_wr_data = 32'(c);
        tick();
        i_wr_en = 1'b0;
    endtask

    task automatic fill(input int pat, input int c);
        for (int r = 0; r < 16; r++)
            for (int k = 0; k < 16; k++) wpix(pat, r, k, c);
    endtask

    task automatic wattr(input int idx, input int x, input int y, input int pat, input logic en);
        i_wr_en = 1'b1; i_wr_sel = 1'b0;
        i_wr_addr = 12'(idx);
        i_wr_data = {en, 10'b0, 4'(pat), 8'(y), 9'(x)};
        tick();
        i_wr_en = 1'b0;
    endtask

    task automatic do_line(input int y, output int cyc, output int ovf);
        i_ypos = 10'(y); i_line_end = 1'b1;
        tick();
        i_line_end = 1'b0;
        cyc = 1; ovf = int'(o_overflow);
        while (o_busy && cyc < 300) begin
            tick();
            cyc++;
            ovf += int'(o_overflow);
        end
        if (cyc >= 300) chk("busy_timeout", cyc, 0);
    endtask

    task automatic run_phase(input int ph, input int y);
        foreach (tv[i]) begin
            if (tv[i].ph == ph) begin
                i_ypos = 10'(y); i_xpos = tv[i].x; i_active = tv[i].act; i_bg_rgb = tv[i].bg;
                tick();
                chk($sformatf("p%0d_x%0d_rgb", ph, tv[i].x), int'(o_rgb), int'(tv[i].rgb));
                chk($sformatf("p%0d_x%0d_hit", ph, tv[i].x), int'(o_sprite_hit), int'(tv[i].hit));
            end
        end
        i_active = 1'b0;
    endtask

    initial begin
        int cyc, ovf;
        // single sprite 10,20 colour 3
        add(1,1,19,5,5,0); add(1,1,20,5,3,1); add(1,1,35,5,3,1); add(1,1,51,5,3,1);
        add(1,1,52,5,5,0); add(1,0,30,5,0,0); add(1,1,36,2,3,1); add(1,1,60,7,7,0);
        // overlapping sprites 2 (colour 6) and 5 (colour 1)
        add(2,1,200,4,6,1); add(2,1,210,4,6,1); add(2,1,208,4,6,1); add(2,1,232,4,4,0);
        add(3,1,208,4,1,1); add(3,1,209,4,1,1); add(3,1,210,4,6,1);
        // overflow line: sprites 0..3 drawn, 4 and 5 dropped
        add(4,1,20,5,3,1); add(4,1,60,5,3,1); add(4,1,100,5,3,1); add(4,1,140,5,3,1);
        add(4,1,180,5,5,0); add(4,1,220,5,5,0);
        add(5,1,20,5,3,1);
        add(6,1,20,5,5,0);
        add(7,1,20,5,5,0);
        add(8,1,20,5,5,0);
        add(9,1,638,5,3,1); add(9,1,620,5,3,1); add(9,1,619,5,5,0); add(9,1,0,5,5,0);
        add(10,1,20,5,5,0);

        resetn = 1'b0;
        tick(); tick();
        chk("reset_rgb", int'(o_rgb), 0);
        chk("reset_hit", int'(o_sprite_hit), 0);
        chk("reset_busy", int'(o_busy), 0);
        chk("reset_ovf", int'(o_overflow), 0);
        resetn = 1'b1;
        i_active = 1'b1; i_bg_rgb = 3'd5; i_xpos = '0;
        tick();
        chk("bg_pass_rgb", int'(o_rgb), 5);
        chk("bg_pass_hit", int'(o_sprite_hit), 0);
        i_active = 1'b0;

        fill(1, 3); fill(2, 6); fill(3, 1);

        wattr(0, 10, 20, 1, 1'b1);
        do_line(39, cyc, ovf);
        chk("a_cycles", cyc, 26);
        chk("a_ovf", ovf, 0);
        run_phase(1, 40);
        do_line(69, cyc, ovf);
        chk("row15_cycles", cyc, 26);
        run_phase(5, 70);
        do_line(71, cyc, ovf);
        chk("row16_cycles", cyc, 9);
        run_phase(6, 72);

        wattr(0, 10, 20, 1, 1'b0);
        wattr(2, 100, 50, 2, 1'b1);
        wattr(5, 100, 50, 3, 1'b1);
        do_line(99, cyc, ovf);
        chk("b_cycles", cyc, 1 + 8 + 2 * 17);
        run_phase(2, 100);
        wpix(2, 0, 4, 0);
        do_line(99, cyc, ovf);
        run_phase(3, 100);

        wattr(2, 0, 0, 0, 1'b0);
        for (int k = 0; k < 6; k++) wattr(k, 20 * k + 10, 30, 1, 1'b1);
        do_line(59, cyc, ovf);
        chk("c_ovf_pulses", ovf, 1);
        chk("c_cycles", cyc, 77);
        run_phase(4, 60);

        for (int k = 1; k < 6; k++) wattr(k, 0, 0, 0, 1'b0);
        wattr(0, 10, 250, 1, 1'b1);
        do_line(3, cyc, ovf);
        chk("wrap_cycles", cyc, 9);
        run_phase(7, 4);

        wattr(0, 10, 20, 1, 1'b1);
        do_line(39, cyc, ovf);
        wattr(0, 10, 0, 1, 1'b1);
        do_line(479, cyc, ovf);
        chk("lastline_cycles", cyc, 1);
        run_phase(8, 0);

        wattr(0, 310, 20, 1, 1'b1);
        do_line(39, cyc, ovf);
        chk("clip_cycles", cyc, 26);
        run_phase(9, 40);

        wattr(0, 10, 20, 1, 1'b1);
        i_active = 1'b1; i_bg_rgb = 3'd5; i_xpos = '0;
        i_ypos = 10'd39; i_line_end = 1'b1;
        tick();
        i_line_end = 1'b0;
        repeat (12) tick();
        chk("f_busy_in_load", int'(o_busy), 1);
        chk("f_rgb_before", int'(o_rgb), 5);
        resetn = 1'b0;
        tick();
        chk("f_busy_after_rst", int'(o_busy), 0);
        chk("f_rgb_after_rst", int'(o_rgb), 0);
        chk("f_hit_after_rst", int'(o_sprite_hit), 0);
        resetn = 1'b1;
        i_active = 1'b0;
        tick();
        do_line(39, cyc, ovf);
        chk("f_cycles_disabled", cyc, 9);
        run_phase(10, 40);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
